irq_controller: RTL

External interrupt controller feeding the CP0 hardware interrupt lines IP[7:4]. It synchronizes up to NSRC peripheral request lines and detects edges or levels per source. It latches pending requests, applies per-source enable masks, and routes each source to one of the four CP0 lines. Software on the core accesses it through a memory-mapped register window to enable, clear and identify sources.

---
 rtl/irq_ctl_pkg.sv | 35 +++
 rtl/irq_sync.sv | 29 ++
 rtl/irq_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/irq_ctl_pkg.sv
// Shared definitions for the external interrupt controller: register offsets,
// CP0 line count and the register-select decode used by the bus interface.
package irq_ctl_pkg;

    localparam logic [4:0] IRQ_PENDING   = 5'h00;
    localparam logic [4:0] IRQ_ENABLE    = 5'h04;
    localparam logic [4:0] IRQ_MODE      = 5'h08;
    localparam logic [4:0] IRQ_MAP       = 5'h0C;
    localparam logic [4:0] IRQ_ACTIVE_ID = 5'h10;

    localparam int NUM_IRQ_LINES       = 4;
    localparam int ACTIVE_ID_VALID_BIT = 31;

    typedef enum logic [2:0] {
        REG_PENDING,
        REG_ENABLE,
        REG_MODE,
        REG_MAP,
        REG_ACTIVE_ID,
        REG_NONE
    } reg_sel_e;

    // Only the word index matters; the byte lanes of the offset are ignored.
    function automatic reg_sel_e decode_word(input logic [2:0] word);
        reg_sel_e sel;
        sel = REG_NONE;
        if (word == IRQ_PENDING[4:2])        sel = REG_PENDING;
        else if (word == IRQ_ENABLE[4:2])    sel = REG_ENABLE;
        else if (word == IRQ_MODE[4:2])      sel = REG_MODE;
        else if (word == IRQ_MAP[4:2])       sel = REG_MAP;
        else if (word == IRQ_ACTIVE_ID[4:2]) sel = REG_ACTIVE_ID;
        return sel;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// One interrupt source: SYNC_STAGES-deep synchronizer for the asynchronous
// request, plus a history flop that turns the synchronized level into a rise pulse.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic src,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_controller.sv
// External interrupt controller driving CP0 IP[7:4]: per-source edge/level
// capture, enable masking, line routing and a memory-mapped register window.
module irq_controller
    import irq_ctl_pkg::*;
#(
    parameter int NSRC        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NSRC-1:0]          irq_src,
    input  logic                     bus_we,
    input  logic                     bus_re,
    input  logic [4:0]               bus_addr,
    input  logic [31:0]              bus_wdata,
    output logic [31:0]              bus_rdata,
    output logic                     bus_rvalid,
    output logic [NUM_IRQ_LINES-1:0] irq_out
);

    logic [NSRC-1:0]   sync_level;
    logic [NSRC-1:0]   sync_rise;
    logic [NSRC-1:0]   pending;
    logic [NSRC-1:0]   enable;
    logic [NSRC-1:0]   mode;
    logic [2*NSRC-1:0] map;

    logic [NSRC-1:0]          pending_next;
    logic [NSRC-1:0]          clear_mask;
    logic [NSRC-1:0]          hit;
    logic [NUM_IRQ_LINES-1:0] irq_next;
    logic [4:0]               active_idx;
    logic                     active_found;
    logic [31:0]              active_word;
    logic [31:0]              rd_word;
    reg_sel_e                 sel;

    logic unused_addr_lanes;
    assign unused_addr_lanes = ^bus_addr[1:0];

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .reset(reset),
            .src  (irq_src[g]),
            .level(sync_level[g]),
            .rise (sync_rise[g])
        );
    end

    assign sel        = decode_word(bus_addr[4:2]);
    assign clear_mask = (bus_we && sel == REG_PENDING) ? bus_wdata[NSRC-1:0] : '0;
    assign hit        = pending & enable;

    // A fresh rise beats a simultaneous W1C; level sources ignore W1C entirely.
    always_comb begin
        pending_next = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (mode[i])
                pending_next[i] = sync_rise[i] | (pending[i] & ~clear_mask[i]);
            else
                pending_next[i] = sync_level[i];
        end
    end

    always_comb begin
        active_found = 1'b0;
        active_idx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (hit[i]) begin
                active_found = 1'b1;
                active_idx   = 5'(i);
            end
        end
        active_word                      = '0;
        active_word[ACTIVE_ID_VALID_BIT] = active_found;
        active_word[4:0]                 = active_idx;
    end

    always_comb begin
        irq_next = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (hit[i]) irq_next[map[2*i +: 2]] = 1'b1;
        end
    end

    always_comb begin
        case (sel)
            REG_PENDING:   rd_word = 32'(pending);
            REG_ENABLE:    rd_word = 32'(enable);
            REG_MODE:      rd_word = 32'(mode);
            REG_MAP:       rd_word = 32'(map);
            REG_ACTIVE_ID: rd_word = active_word;
            default:       rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            enable     <= '0;
            mode       <= '0;
            map        <= '0;
            irq_out    <= '0;
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
        end else begin
            pending <= pending_next;
            if (bus_we) begin
                case (sel)
                    REG_ENABLE: enable <= bus_wdata[NSRC-1:0];
                    REG_MODE:   mode   <= bus_wdata[NSRC-1:0];
                    REG_MAP:    map    <= bus_wdata[2*NSRC-1:0];
                    default:    ;
                endcase
            end
            irq_out    <= irq_next;
            bus_rvalid <= bus_re;
            // rd_word reflects the registers before this edge's write.
            bus_rdata  <= bus_re ? rd_word : '0;
        end
    end

endmodule
